// File: rtl/fir_pkg.sv
// Shared types and the saturating power-of-two gain used by the FIR output stage.
package fir_pkg;

  localparam int D_W_DEF = 16;

  typedef logic signed [D_W_DEF-1:0] sample_t;

  typedef struct packed {
    sample_t data;
    logic    clipped;
  } sat_t;

  // Seven guard bits cover the largest shift, so the clip test only has to
  // check that every bit above the Q0.15 sign bit agrees with it.
  function automatic sat_t sat_shl(sample_t x, logic [2:0] sh);
    logic signed [D_W_DEF+6:0] w;
    sat_t r;
    w = {{7{x[D_W_DEF-1]}}, x};
    w = w <<< sh;
    r.clipped = (w[D_W_DEF+6:D_W_DEF-1] != {8{w[D_W_DEF+6]}});
    if (r.clipped) begin
      r.data = {w[D_W_DEF+6], {(D_W_DEF-1){~w[D_W_DEF+6]}}};
    end else begin
      r.data = w[D_W_DEF-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head entry and wrap-bit pointers.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = dout_q;

  // The head register is refilled from the incoming word when the FIFO
  // would otherwise be empty, so no fall-through path exists.
  always_comb begin
    wr_d   = wr_q + (AW+1)'(push_ok);
    rd_d   = rd_q + (AW+1)'(pop_ok);
    dout_d = dout_q;
    if (push_ok && (rd_d == wr_q)) begin
      dout_d = din;
    end else if (pop_ok) begin
      dout_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: runtime decimation, saturating power-of-two gain, and an
// output FIFO with drop accounting toward a valid/ready consumer.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int DEPTH = 4,
  parameter int DEC_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [D_W-1:0]   in_data,
  input  logic             in_valid,
  input  logic [DEC_W-1:0] dec_factor,
  input  logic [2:0]       gain_shl,
  output logic [D_W-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             sat_hit
);

  logic [DEC_W-1:0] phase_q, phase_d, factor_q, factor_d, fac_new;
  logic             keep;
  sample_t          data_p1_q, data_p2_q;
  logic             vld_p1_q, vld_p2_q, clip_p2_q;
  sat_t             sat_p1;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty, full, push, pop, drop;

  // Stage 0: decimator; a new factor is only adopted at a kept sample.
  assign keep    = in_valid & (phase_q == '0);
  assign fac_new = (dec_factor == '0) ? DEC_W'(1) : dec_factor;

  always_comb begin
    phase_d  = phase_q;
    factor_d = factor_q;
    if (keep) begin
      factor_d = fac_new;
      phase_d  = (fac_new == DEC_W'(1)) ? '0 : DEC_W'(1);
    end else if (in_valid) begin
      phase_d = (phase_q == factor_q - DEC_W'(1)) ? '0 : phase_q + DEC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q  <= '0;
      factor_q <= DEC_W'(1);
      vld_p1_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      factor_q <= factor_d;
      vld_p1_q <= keep;
    end
  end

  always_ff @(posedge clock) begin
    if (keep) begin
      data_p1_q <= in_data;
    end
  end

  // Stage 1: gain and saturation.
  assign sat_p1 = sat_shl(data_p1_q, gain_shl);

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
    end
  end

  always_ff @(posedge clock) begin
    data_p2_q <= sat_p1.data;
    clip_p2_q <= sat_p1.clipped;
  end

  // Stage 2: FIFO push, drop accounting.
  assign pop     = ~empty & out_ready;
  assign push    = vld_p2_q & (~full | pop);
  assign drop    = vld_p2_q & ~push;
  assign sat_hit = push & clip_p2_q;

  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr_ovf) begin
      ovf_d = drop;
      cnt_d = CNT_W'(drop);
    end else if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH(D_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .din  (data_p2_q),
    .pop  (pop),
    .dout (out_data),
    .empty(empty),
    .full (full)
  );

  assign out_valid = ~empty;
  assign ovf       = ovf_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_fir_decim_out.sv
// Randomized and directed bench for fir_decim_out against a queue-based model.
module tb_fir_decim_out;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset, in_valid, out_ready, clr_ovf;
  logic [15:0] in_data;
  logic [3:0]  dec_factor;
  logic [2:0]  gain_shl;
  logic [15:0] out_data;
  logic        out_valid, ovf, sat_hit;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  int q[$];
  bit m_s1v, m_s2v, m_s2c, m_ovf;
  int m_s1d, m_s2d, m_keep, m_cnt;

  always #5 clock = ~clock;

  fir_decim_out dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .dec_factor(dec_factor), .gain_shl(gain_shl), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .clr_ovf(clr_ovf),
    .drop_cnt(drop_cnt), .sat_hit(sat_hit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: samples counted down between keeps, gain by multiplication,
  // FIFO as a bounded queue.
  task automatic model_step();
    bit pop, pushok, drop;
    int v, f;
    if (reset) begin
      q.delete();
      m_s1v = 0; m_s2v = 0; m_keep = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    pop    = (q.size() > 0) && out_ready;
    pushok = m_s2v && ((q.size() < DEPTH) || pop);
    drop   = m_s2v && !pushok;
    if (clr_ovf) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (pop) void'(q.pop_front());
    if (pushok) q.push_back(m_s2d);
    m_s2v = m_s1v;
    if (m_s1v) begin
      v = m_s1d * (1 << int'(gain_shl));
      m_s2c = (v > 32767) || (v < -32768);
      m_s2d = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
    end
    m_s1v = 0;
    if (in_valid) begin
      if (m_keep == 0) begin
        m_s1v  = 1;
        m_s1d  = int'($signed(in_data));
        f      = (dec_factor == 0) ? 1 : int'(dec_factor);
        m_keep = f - 1;
      end else begin
        m_keep--;
      end
    end
  endtask

  task automatic cycle();
    bit exp_sat;
    @(negedge clock);
    exp_sat = m_s2v && m_s2c &&
              ((q.size() < DEPTH) || ((q.size() > 0) && out_ready));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0] & 32'hFFFF));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
    check("sat_hit", 32'(sat_hit), 32'(exp_sat));
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit done;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; dec_factor = 4'd1;
    gain_shl = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    repeat (2) @(posedge clock);
    model_step();
    #1;
    cycle();
    check("rst_data", 32'(out_data), 32'h0);
    reset = 1'b0;

    // Decimate by 3 on a ramp.
    dec_factor = 4'd3;
    for (int i = 1; i <= 12; i++) send(16'(i));
    idle(5);

    // Gain 4 with saturation at both rails.
    dec_factor = 4'd1; gain_shl = 3'd2;
    send(16'h1000); send(16'h2001); send(16'hE000); send(16'hC000);
    idle(5);
    gain_shl = 3'd0;

    // Backpressure: four entries held, four dropped.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'(i));
    idle(3);
    check("bp_drop_cnt", 32'(drop_cnt), 32'd4);
    check("bp_ovf", 32'(ovf), 32'd1);
    check("bp_head", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    idle(6);

    // Full FIFO popped in the same cycle a new sample arrives.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_s2v && (q.size() == DEPTH)) out_ready = 1'b1;
      send(16'(16'h0100 + i));
    end
    idle(8);
    check("full_pop_cnt", 32'(drop_cnt), 32'd4);

    // Factor change mid-frame, then factor 0.
    dec_factor = 4'd4;
    for (int i = 0; i < 6; i++) send(16'(16'h0200 + i));
    dec_factor = 4'd2;
    for (int i = 6; i < 16; i++) send(16'(16'h0200 + i));
    dec_factor = 4'd0;
    for (int i = 0; i < 6; i++) send(16'(16'h0300 + i));
    idle(6);

    // Reset with three entries queued.
    out_ready = 1'b0; dec_factor = 4'd1;
    for (int i = 0; i < 3; i++) send(16'(16'h0400 + i));
    idle(3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_cnt", 32'(drop_cnt), 32'd0);

    // Clear coinciding with a drop.
    done = 0;
    for (int i = 0; i < 8; i++) begin
      clr_ovf  = !done && m_s2v && (q.size() == DEPTH);
      send(16'(16'h0500 + i));
      if (clr_ovf) begin
        clr_ovf = 1'b0;
        done = 1;
        check("clr_drop_ovf", 32'(ovf), 32'd1);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd1);
      end
    end
    clr_ovf = 1'b0;
    check("clr_seen", 32'(done), 32'd1);

    // Drop counter saturation.
    for (int i = 0; i < 270; i++) send(16'(i));
    idle(3);
    check("cnt_sat", 32'(drop_cnt), 32'hFF);
    clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      clr_ovf   = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) dec_factor = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) gain_shl = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      cycle();
    end
    reset = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Output stage directly downstream of the single-channel FIR.
- Takes one filtered Q0.15 sample per clock, decimates by a runtime factor, and applies a power-of-two gain with saturation.
- Buffers results in a small FIFO and presents them to the consumer over a valid/ready handshake.
- Reports dropped samples when the consumer stalls.

Parameters:
- D_W, 16: sample width, signed Q0.15, same as FIR data width.
- DEPTH, 4: output FIFO depth in entries, power of two, ≥2.
- DEC_W, 4: width of the decimation factor input.
- CNT_W, 8: width of the drop counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  D_W  signed FIR output sample.
- in_valid  in  1  in_data is valid this cycle; no backpressure upstream.
- dec_factor  in  DEC_W  decimation factor R; 0 is treated as 1.
- gain_shl  in  3  left-shift gain, 0..7.
- out_data  out  D_W  signed scaled sample, head of FIFO.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- ovf  out  1  sticky: a kept sample was dropped because the FIFO was full.
- clr_ovf  in  1  clears ovf and drop_cnt.
- drop_cnt  out  CNT_W  count of dropped samples, saturates at all-ones.
- sat_hit  out  1  one-cycle pulse: the sample pushed this cycle was clipped.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FIFO empty, phase=0, factor_q=1, pipeline valids cleared. Reset mid-operation discards FIFO contents and in-flight samples.

Stage 0, decimator:
- phase counter advances only on in_valid.
- A sample is kept when in_valid and phase==0.
- On a kept sample, factor_q loads max(dec_factor,1). The next phase is 0 if the new factor_q==1, otherwise 1.
- Otherwise, on in_valid, phase = (phase==factor_q-1) ? 0 : phase+1.
- dec_factor changes therefore take effect only at a kept sample, which is the frame boundary.
- The kept sample registers into s1 (data, valid).

Stage 1, gain and saturation:
- Widen s1 data to D_W+7 bits, shift left by gain_shl (sampled in the same cycle).
- Clip to [-2^(D_W-1), 2^(D_W-1)-1]: 0x7FFF / 0x8000 for D_W=16.
- Result registers into s2 (data, valid, clipped).

Stage 2, FIFO push:
- Push when s2 valid and FIFO is not full, or when full and a pop occurs in the same cycle (simultaneous push+pop when full is accepted).
- sat_hit = s2.valid & s2.clipped & push.
- If s2 is valid and the push is refused: the sample is discarded, ovf is set, drop_cnt increments (saturating).
- clr_ovf asserted in the same cycle as a new drop: ovf ends at 1 and drop_cnt ends at 1.

Latency and FIFO:
- Latency: a kept sample at cycle t has out_valid high at t+3 when the FIFO was empty.
- FIFO pop on out_valid & out_ready. out_data is the registered head entry; it holds stable while out_valid & !out_ready.
- Pop on empty has no effect. Push and pop on empty: out_valid rises the next cycle, with no fall-through.
- No combinational path from out_ready to in-side logic; the only in→out path is registered.
- Throughput: one sample per clock at R=1 with out_ready held high, no drops.

Decomposition:
- Package fir_pkg holds:
  - D_W default constant.
  - typedef sample_t (logic signed [D_W-1:0]).
  - function sat_shl(sample_t x, 3-bit sh) returning {sample_t, clipped}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports clock, reset, push, din, pop, dout, empty, full;
  - registered output;
  - pointer with an extra wrap bit.
- fir_decim_out instantiates sync_fifo with WIDTH=D_W.
- Expected size: roughly 180 lines total.

Test Plan:
- Decimate by 3: R=3, gain 0, ramp 1,2,3,...,12 on consecutive cycles, out_ready=1 → outputs 1,4,7,10; first out_valid 3 cycles after sample 1.
- Gain and saturation: R=1, gain_shl=2, inputs 0x1000, 0x2001, 0xE000, 0xC000 → 0x4000, 0x7FFF (sat_hit), 0x8000, 0x8000 (sat_hit).
- Backpressure and overflow: R=1, out_ready=0, 8 samples 1..8 → FIFO holds 1..4, drop_cnt=4 (DEPTH=4, 4 dropped), ovf=1; then out_ready=1 → drains 1,2,3,4 in order.
- Full with simultaneous pop: FIFO full, out_ready=1 with a push arriving the same cycle → no drop, count stays 4, output order preserved.
- Factor change mid-frame and R=0: R=4 running; set dec_factor=2 at phase 2 → new spacing starts at the next kept sample. dec_factor=0 → every sample kept.
- Reset and clear: assert reset with 3 entries queued → out_valid=0 next cycle, drop_cnt=0. Pulse clr_ovf in the same cycle as a drop → ovf=1, drop_cnt=1.
